// File: rtl/lpc_pkg.sv
// ---------------------------------------------------------------------------
// lpc_pkg
// Shared definitions for the LPC autocorrelation datapath.
//   SAMPLE_W  : sample width in bits
//   LAG_DEPTH : number of delay stages in the lag generator
//   sample_t  : one audio sample
// ---------------------------------------------------------------------------
package lpc_pkg;

  localparam int SAMPLE_W  = 16;
  localparam int LAG_DEPTH = 10;

  typedef logic [SAMPLE_W-1:0] sample_t;

endpackage : lpc_pkg

// File: rtl/shift_1x10_onehot_mux.sv
// ---------------------------------------------------------------------------
// onehot_mux
// Priority select of one of N W-bit inputs by a one-hot select vector.
// The lowest set bit of sel wins when several are set; with no bit set the
// output is zero. Purely combinational.
// Ports:
//   sel   in  [N-1:0]          select vector, bit i selects data[i]
//   data  in  [N-1:0][W-1:0]   candidate inputs
//   out   out [W-1:0]          selected input, or zero
// ---------------------------------------------------------------------------
module onehot_mux #(
  parameter int N = 11,
  parameter int W = 16
) (
  input  logic [N-1:0]        sel,
  input  logic [N-1:0][W-1:0] data,
  output logic [W-1:0]        out
);

  always_comb begin
    // NOTE: the default assignment up front keeps this block free of latches;
    // blocking assignments are correct here because it is combinational.
    out = '0;
    // Walk from the top index down so the lowest set bit is the last
    // assignment and therefore takes priority.
    for (int i = N - 1; i >= 0; i--) begin
      if (sel[i]) out = data[i];
    end
  end

endmodule : onehot_mux

// File: rtl/shift_1x10.sv
// ---------------------------------------------------------------------------
// shift_1x10
// Tapped delay line used as the lag generator of the LPC autocorrelation
// datapath. One sample enters per clock into a DEPTH-stage shift register;
// a one-hot tap vector picks which delay (0..DEPTH samples) drives dout.
// Lag 0 is din itself. tap == 0 gives zero; several set bits -> lowest wins.
// Ports:
//   clk   in  1          rising-edge clock
//   rst   in  1          synchronous active-high reset, clears every stage
//   tap   in  DEPTH+1    one-hot lag select, bit k = delay k
//   din   in  WIDTH      sample input, one per clock
//   dout  out WIDTH      selected delayed sample
// Configuration:
//   SHIFT_1X10_OUTREG_EN  when defined, dout is registered (reset to 0) and
//                         every lag gains one cycle of latency. Undefined:
//                         the output mux is combinational.
// ---------------------------------------------------------------------------
module shift_1x10
  import lpc_pkg::*;
#(
  parameter int WIDTH = SAMPLE_W,
  parameter int DEPTH = LAG_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DEPTH:0]   tap,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  // stage[k] holds din as sampled k rising edges ago.
  logic [WIDTH-1:0]            stage [1:DEPTH];
  logic [DEPTH:0][WIDTH-1:0]   lag_bus;
  logic [WIDTH-1:0]            sel_value;

  // NOTE: every stage is cleared by reset -- these are individual registers
  // whose zero content is observable on dout, not a RAM, so resetting them
  // is required rather than wasteful.
  for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
    always_ff @(posedge clk) begin
      // NOTE: non-blocking assignment so every stage samples its predecessor's
      // pre-edge value and the chain moves exactly one step per clock.
      if (rst) stage[k] <= '0;
      else if (k == 1) stage[k] <= din;
      else stage[k] <= stage[k-1];
    end
  end

  // Lag 0 is the live input; lags 1..DEPTH come from the register chain.
  always_comb begin
    lag_bus[0] = din;
    for (int k = 1; k <= DEPTH; k++) begin
      lag_bus[k] = stage[k];
    end
  end

  onehot_mux #(
    .N (DEPTH + 1),
    .W (WIDTH)
  ) u_tap_mux (
    .sel  (tap),
    .data (lag_bus),
    .out  (sel_value)
  );

`ifdef SHIFT_1X10_OUTREG_EN
  always_ff @(posedge clk) begin
    if (rst) dout <= '0;
    else     dout <= sel_value;
  end
`else
  assign dout = sel_value;
`endif

endmodule : shift_1x10

// File: tb/tb_shift_1x10.sv
// ---------------------------------------------------------------------------
// tb_shift_1x10
// Self-checking bench for shift_1x10. A history model of the delay line
// produces the expected tap output each cycle; expectations are queued when
// stimulus is applied and popped when the DUT output for that cycle is due
// (same cycle for the combinational build, one cycle later when
// SHIFT_1X10_OUTREG_EN is defined).
// ---------------------------------------------------------------------------
module tb_shift_1x10;
  import lpc_pkg::*;

  localparam int W = SAMPLE_W;
  localparam int D = LAG_DEPTH;
`ifdef SHIFT_1X10_OUTREG_EN
  localparam int OUT_LAT = 1;
`else
  localparam int OUT_LAT = 0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [D:0]   tap;
  logic [W-1:0] din;
  logic [W-1:0] dout;

  always #5 clk = ~clk;

  shift_1x10 dut (
    .clk  (clk),
    .rst  (rst),
    .tap  (tap),
    .din  (din),
    .dout (dout)
  );

  // Model: hist[k] = din sampled k edges ago; X until reset clears it.
  logic [W-1:0] hist [1:D];
  logic [W-1:0] sb_q [$];
  logic [W-1:0] exp_v;
  int vectors     = 0;
  int miscompares = 0;
  int ramp        = 0;

  initial begin
    for (int k = 1; k <= D; k++) hist[k] = 'x;
  end

  function automatic logic [W-1:0] model_sel(input logic [D:0] t, input logic [W-1:0] d);
    for (int k = 0; k <= D; k++) begin
      if (t[k]) return (k == 0) ? d : hist[k];
    end
    return '0;
  endfunction

  function automatic logic [W-1:0] next_ramp();
    logic [W-1:0] v;
    v    = W'(ramp);
    ramp = (ramp + 1) % 160;
    return v;
  endfunction

  // Apply inputs just after a rising edge, then at the falling edge queue the
  // value the DUT must show OUT_LAT cycles from now.
  task automatic drive(input logic r, input logic [D:0] t, input logic [W-1:0] d);
    logic [W-1:0] e;
    rst = r;
    tap = t;
    din = d;
    @(negedge clk);
    e = model_sel(t, d);
    if (OUT_LAT == 1 && r) e = '0;
    sb_q.push_back(e);
  endtask

  // Advance the model across the rising edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int k = 1; k <= D; k++) hist[k] = '0;
    end else begin
      for (int k = D; k >= 2; k--) hist[k] = hist[k-1];
      hist[1] = din;
    end
    #1;
  endtask

  task automatic test_reset();
    logic [D:0] t;
    t = '0;
    t[D] = 1'b1;
    for (int i = 0; i < 2 + D + 20; i++) begin
      drive(i < 2, t, next_ramp());
      if (sb_q.size() > OUT_LAT) begin
        exp_v = sb_q.pop_front();
        if (!$isunknown(exp_v)) begin
          vectors++;
          if (dout !== exp_v) begin
            miscompares++;
            $display("FAIL reset cyc%0d: dout=%h expected %h", i, dout, exp_v);
          end
        end
      end
      tick();
    end
  endtask

  task automatic test_lag0();
    for (int i = 0; i < 160; i++) begin
      drive(1'b0, (D+1)'(1), next_ramp());
      if (sb_q.size() > OUT_LAT) begin
        exp_v = sb_q.pop_front();
        vectors++;
        if (dout !== exp_v) begin
          miscompares++;
          $display("FAIL lag0 cyc%0d: dout=%h expected %h", i, dout, exp_v);
        end
      end
      tick();
    end
  endtask

  task automatic test_sweep();
    logic [D:0] t;
    for (int k = 0; k <= D; k++) begin
      t = '0;
      t[k] = 1'b1;
      for (int i = 0; i < 160; i++) begin
        drive(1'b0, t, next_ramp());
        if (sb_q.size() > OUT_LAT) begin
          exp_v = sb_q.pop_front();
          vectors++;
          if (dout !== exp_v) begin
            miscompares++;
            $display("FAIL sweep lag%0d cyc%0d: dout=%h expected %h", k, i, dout, exp_v);
          end
        end
        tick();
      end
    end
  endtask

  task automatic test_tap_edge();
    for (int i = 0; i < 40; i++) begin
      // First half: no tap selected; second half: bits 2 and 4 -> lag 2 wins.
      drive(1'b0, (i < 20) ? (D+1)'(0) : (D+1)'('b000_0001_0100), next_ramp());
      if (sb_q.size() > OUT_LAT) begin
        exp_v = sb_q.pop_front();
        vectors++;
        if (dout !== exp_v) begin
          miscompares++;
          $display("FAIL tap_edge cyc%0d tap=%b: dout=%h expected %h", i, tap, dout, exp_v);
        end
      end
      tick();
    end
  endtask

  task automatic test_mid_reset();
    logic [D:0] t;
    t = '0;
    t[5] = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (i == 10) drive(1'b1, t, W'(100));
      else         drive(1'b0, t, next_ramp());
      if (sb_q.size() > OUT_LAT) begin
        exp_v = sb_q.pop_front();
        vectors++;
        if (dout !== exp_v) begin
          miscompares++;
          $display("FAIL mid_reset cyc%0d: dout=%h expected %h", i, dout, exp_v);
        end
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    tap = '0;
    din = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_lag0();
    test_sweep();
    test_tap_edge();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_shift_1x10
